ir_nec_tx: RTL
==============

# ir_nec_tx

NEC-protocol infrared transmitter: the send-side counterpart to the IR receive path (IR_RECEIVE → ir_controller). On a one-cycle `start` it serialises a 32-bit word as a full NEC frame. On `repeat_req` it sends an NEC repeat code instead. The output is a 38 kHz-modulated drive for an IR LED on a GPIO pin, plus an unmodulated envelope for debug and loopback. Bit packing matches IR_RECEIVE `oDATA`, so a tx→rx loopback returns the same word.

## Interface
- `UNIT_CYC`, 28125, clocks per NEC unit T (562.5 µs at 50 MHz)
- `CARRIER_DIV`, 1316, clocks per carrier period (≈38 kHz)
- `CARRIER_HIGH`, 438, carrier high clocks per period (≈1/3 duty)
- `GAP_UNITS`, 72, enforced idle space after each frame, in T
- `clk`  in  1  system clock (CLOCK_50)
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to send a full frame of `tx_data`
- `repeat_req`  in  1  one-cycle request to send a repeat code
- `tx_data`  in  32  frame payload; sampled only when `start` is accepted
- `busy`  out  1  high from acceptance until the gap ends
- `done`  out  1  one-cycle pulse at the end of the gap
- `ir_env`  out  1  mark envelope (1 = carrier on)
- `ir_tx`  out  1  modulated LED drive = `ir_env` & carrier

## Operation
- **Reset values:** `busy`, `done`, `ir_env` and `ir_tx` are all 0; the state machine is IDLE; all counters are 0.
- **Acceptance:** in IDLE, `start` latches `tx_data` into the shift register.
  - If `start` and `repeat_req` are both high, `start` wins.
  - While `busy` is high, both requests are ignored (no queueing).
- **States and durations** (each duration counted by a unit counter and a unit-count register):
  - LEAD_MARK: 16T, env = 1.
  - LEAD_SPACE: 8T for a frame, 4T for a repeat, env = 0. A repeat then goes directly to STOP_MARK.
  - BIT_MARK: 1T, env = 1.
  - BIT_SPACE: 1T if the current bit is 0, 3T if it is 1, env = 0.
  - After 32 bits: STOP_MARK, 1T, env = 1.
  - GAP: `GAP_UNITS`·T, env = 0.
  - Then IDLE.
- **Bit order:** `tx_data[0]` is sent first and `tx_data[31]` last; the register shifts right once per BIT_SPACE exit. A 6-bit bit counter wraps at 32 into STOP_MARK.
- **Frame length:** 89T + 2T per '1' bit. A repeat code is 21T. Both are followed by the gap.
- **Carrier:**
  - The counter runs 0..`CARRIER_DIV`-1 and wraps; carrier = 1 while the count < `CARRIER_HIGH`.
  - The counter is cleared to 0 on every entry to a mark state, so every mark begins with a carrier high phase.
  - `ir_tx` is 0 whenever env = 0.
- **Counter widths:** unit counter ≥ clog2(`UNIT_CYC`); unit-count register ≥ clog2(max(16, `GAP_UNITS`)+1). No overflow is permitted for the defaults.
- **Reset mid-frame:** all outputs drop to 0 immediately (asynchronous). The frame is abandoned with no `done`.

## Timing
- Request sampled at rising edge E. From E+1: `busy` = 1 and `ir_env` = 1 (LEAD_MARK).
- Each state lasts exactly its unit count × `UNIT_CYC` clocks. There are no extra transition cycles; state changes coincide with the last cycle of the unit counter.
- Last GAP cycle at E + N·`UNIT_CYC`, where N = frame units + `GAP_UNITS`.
- At E + N·`UNIT_CYC` + 1: `done` = 1 for one cycle, `busy` = 0, state is IDLE.
- A new `start` presented in the same cycle as `done` is accepted.
- `ir_env` and `ir_tx` are registered outputs, with no combinational path from any input.

## Test plan
Sim parameters for all scenarios: `UNIT_CYC`=10, `CARRIER_DIV`=4, `CARRIER_HIGH`=1, `GAP_UNITS`=5.
- **All-zero frame:** `start` with `tx_data`=0x00000000 at E.
  - Required: `ir_env` high for cycles E+1..E+160 and low for 80.
  - Required: then 32 × (10 high, 10 low), then 10 high, then 50 low.
  - Required: `done` at E+941.
- **All-ones frame:** `tx_data`=0xFFFFFFFF.
  - Required: every bit space is 30 cycles.
  - Required: `done` at E+1+(153+5)·10 = E+1581.
- **Loopback/bit order:** `tx_data`=0xBF40FF00.
  - Required: the decoded space lengths give LSB-first bits 0,0,0,0,0,0,0,0,1,…
  - Required: the reconstructed word equals 0xBF40FF00.
- **Repeat code:** `repeat_req` at E.
  - Required: env 160 high, 40 low, 10 high, 50 low.
  - Required: `done` at E+261.
  - Also: `start` and `repeat_req` asserted together → a full frame is sent.
- **Carrier and busy:**
  - Required: during every mark `ir_tx` follows the pattern 1,0,0,0 from the first mark cycle.
  - Required: `ir_tx` is 0 throughout every space.
  - Required: a `start` pulsed mid-frame is ignored and `tx_data` changes mid-frame have no effect.
- **Reset mid-frame:** deassert `rst_n` during BIT_SPACE.
  - Required: `ir_tx`, `ir_env`, `busy` and `done` are all 0 immediately.
  - Required: after release, a `start` with 0x00000000 produces a clean frame with `done` at E+941.

Source files
------------

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter.
// Sends a 32-bit word as a full NEC frame, or sends a repeat code. Each frame
// or repeat code is followed by an idle gap. The first bit sent is the LSB,
// which is the packing the IR receive path expects. The outputs are a mark
// envelope and a carrier-modulated LED drive, and both are registered.
module ir_nec_tx #(
  parameter int UNIT_CYC     = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 438,
  parameter int GAP_UNITS    = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        repeat_req,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_tx
);

  localparam int UW      = $clog2(UNIT_CYC > 1 ? UNIT_CYC : 2);
  localparam int MAX_UNT = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int NW      = $clog2(MAX_UNT + 1);
  localparam int CW      = $clog2(CARRIER_DIV > 1 ? CARRIER_DIV : 2);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP_MARK  = 3'd5;
  localparam logic [2:0] S_GAP        = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [UW-1:0] cyc_q, cyc_d;
  logic [NW-1:0] units_q, units_d;
  logic [NW-1:0] tgt_units;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    bit_q, bit_d;
  logic          rpt_q, rpt_d;
  logic [CW-1:0] car_q, car_d;
  logic          busy_q, done_q, env_q, tx_q;
  logic          done_d, mark_d, enter_mark, unit_end, state_end;

  // Number of units the current state lasts.
  always_comb begin
    tgt_units = NW'(1);
    case (state_q)
      S_LEAD_MARK:  tgt_units = NW'(16);
      S_LEAD_SPACE: tgt_units = rpt_q ? NW'(4) : NW'(8);
      S_BIT_MARK:   tgt_units = NW'(1);
      S_BIT_SPACE:  tgt_units = sr_q[0] ? NW'(3) : NW'(1);
      S_STOP_MARK:  tgt_units = NW'(1);
      S_GAP:        tgt_units = NW'(GAP_UNITS);
      default:      tgt_units = NW'(1);
    endcase
  end

  assign unit_end  = (cyc_q == UW'(UNIT_CYC - 1));
  assign state_end = unit_end && (units_q == (tgt_units - NW'(1)));

  // Next-state logic: request acceptance, unit timing and frame sequencing.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    units_d = units_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      cyc_d   = '0;
      units_d = '0;
      if (start) begin
        state_d = S_LEAD_MARK;
        sr_d    = tx_data;
        bit_d   = '0;
        rpt_d   = 1'b0;
      end else if (repeat_req) begin
        state_d = S_LEAD_MARK;
        rpt_d   = 1'b1;
      end
    end else begin
      if (unit_end) begin
        cyc_d   = '0;
        units_d = units_q + NW'(1);
      end else begin
        cyc_d = cyc_q + UW'(1);
      end
      if (state_end) begin
        units_d = '0;
        case (state_q)
          S_LEAD_MARK:  state_d = S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = rpt_q ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            sr_d = sr_q >> 1;
            if (bit_q == 6'd31) begin
              bit_d   = '0;
              state_d = S_STOP_MARK;
            end else begin
              bit_d   = bit_q + 6'd1;
              state_d = S_BIT_MARK;
            end
          end
          S_STOP_MARK:  state_d = S_GAP;
          S_GAP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:      state_d = S_IDLE;
        endcase
      end
    end
  end

  // Carrier phase: restarts on every mark entry so each mark opens high.
  always_comb begin
    mark_d     = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                 (state_d == S_STOP_MARK);
    enter_mark = mark_d && (state_d != state_q);
    if (enter_mark || (car_q == CW'(CARRIER_DIV - 1))) begin
      car_d = '0;
    end else begin
      car_d = car_q + CW'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      units_q <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      rpt_q   <= 1'b0;
      car_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      rpt_q   <= rpt_d;
      car_q   <= car_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      env_q   <= mark_d;
      tx_q    <= mark_d && (32'(car_d) < CARRIER_HIGH);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ir_env = env_q;
  assign ir_tx  = tx_q;

endmodule
